inst_fifo: RTL

- Instruction buffer between fetch and the dual-issue decode/issue stage.
- Accepts 0–2 fetched instructions per cycle from the 64-bit I-cache path.
- Presents the two oldest entries as master/slave candidates and retires 0–2 per cycle according to what issue accepted.
- Generates the empty/almost_empty status that gates slave issue, the full status that stalls fetch, and supports branch flush with delay-slot retention.

---
 rtl/inst_fifo_pkg.sv | 11 +
 rtl/inst_fifo_ram.sv | 36 +++
 rtl/inst_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/inst_fifo_pkg.sv
// Shared definitions for the fetch-to-issue instruction buffer.
package inst_fifo_pkg;

  localparam int INST_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/inst_fifo_ram.sv
// Instruction buffer storage: two write ports, two async read ports and an
// in-place copy of one entry to slot 0 (keep-head flush).
module inst_fifo_ram
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] waddr_a,
  input  logic [63:0]   wdata_a,
  input  logic          we_b,
  input  logic [AW-1:0] waddr_b,
  input  logic [63:0]   wdata_b,
  input  logic          cp_en,
  input  logic [AW-1:0] cp_src,
  input  logic [AW-1:0] raddr_a,
  output logic [63:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [63:0]   rdata_b
);

  fifo_entry_t mem [DEPTH];

  // The copy is issued last so it wins over a normal write to slot 0.
  always_ff @(posedge clk) begin
    if (we_a)  mem[waddr_a] <= wdata_a;
    if (we_b)  mem[waddr_b] <= wdata_b;
    if (cp_en) mem[0]       <= mem[cp_src];
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction buffer between fetch and dual issue,
// with branch flush that can retain the delay-slot entry.
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          flush_keep_head,
  input  logic          write_en1,
  input  logic          write_en2,
  input  logic [31:0]   write_inst1,
  input  logic [31:0]   write_inst2,
  input  logic [31:0]   write_pc1,
  input  logic [31:0]   write_pc2,
  input  logic          read_en1,
  input  logic          read_en2,
  output logic [31:0]   read_inst1,
  output logic [31:0]   read_inst2,
  output logic [31:0]   read_pc1,
  output logic [31:0]   read_pc2,
  output logic          empty,
  output logic          almost_empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] head, tail, head_nxt, tail_nxt, keep_src;
  logic [AW:0]   count_nxt, survivors;
  logic [1:0]    pops, pushes;
  logic          pop1, pop2, push1, push2, keep;
  logic [63:0]   rd_a, rd_b;
  fifo_entry_t   ent_a, ent_b;

  assign empty        = (count == '0);
  assign almost_empty = (count == ONE);
  assign full         = (count >= FULL_LVL);

  always_comb begin
    pop1      = read_en1 && !empty;
    pop2      = pop1 && read_en2 && (count > ONE);
    push1     = write_en1 && !full;
    push2     = push1 && write_en2;
    pops      = 2'(pop1) + 2'(pop2);
    pushes    = 2'(push1) + 2'(push2);
    survivors = count - (AW+1)'(pops);
    keep      = flush && flush_keep_head && (survivors != '0);
    keep_src  = head + AW'(pops);
    head_nxt  = head + AW'(pops);
    tail_nxt  = tail + AW'(pushes);
    count_nxt = count + (AW+1)'(pushes) - (AW+1)'(pops);
    // A keep-head flush relocates the surviving entry to slot 0.
    if (flush) begin
      head_nxt  = '0;
      tail_nxt  = keep ? AW'(1) : '0;
      count_nxt = keep ? ONE : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

  inst_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_a    (push1 && !flush),
    .waddr_a (tail),
    .wdata_a ({write_inst1, write_pc1}),
    .we_b    (push2 && !flush),
    .waddr_b (tail + AW'(1)),
    .wdata_b ({write_inst2, write_pc2}),
    .cp_en   (keep),
    .cp_src  (keep_src),
    .raddr_a (head),
    .rdata_a (rd_a),
    .raddr_b (head + AW'(1)),
    .rdata_b (rd_b)
  );

  assign ent_a = rd_a;
  assign ent_b = rd_b;

  // Unoccupied slots read as zero so issue never sees stale instructions.
  assign read_inst1 = (count >= ONE) ? ent_a.inst : '0;
  assign read_pc1   = (count >= ONE) ? ent_a.pc   : '0;
  assign read_inst2 = (count >  ONE) ? ent_b.inst : '0;
  assign read_pc2   = (count >  ONE) ? ent_b.pc   : '0;

endmodule
